// File: rtl/bridge_occupancy_counter.sv
// Drawbridge deck occupancy counter with entry gating and lift-clear handshake.
// Optional macro SENSOR_SYNC_EN adds a 2-flop synchroniser on each car sensor.
module bridge_occupancy_counter #(
  parameter int CNT_W      = 6,
  parameter int CAPACITY   = 40,
  parameter int CLEAR_HOLD = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             CarIn,
  input  logic             CarOut,
  input  logic             LiftReq,
  input  logic             ClearErr,
  output logic [CNT_W-1:0] Count,
  output logic             ExistCar,
  output logic             Full,
  output logic             GateOpen,
  output logic             LiftOk,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Intrusion
);

  localparam int HOLD_W = $clog2(CLEAR_HOLD + 1);
  localparam logic [CNT_W-1:0]  CAP      = CNT_W'(CAPACITY);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(CLEAR_HOLD);

  typedef enum logic [1:0] {OPEN, DRAINING, CLEAR} state_t;

  state_t            state, stateNext;
  logic [HOLD_W-1:0] holdCnt, holdNext;
  logic              carInS, carOutS, prevIn, prevOut, inEdge, outEdge;
  logic [CNT_W-1:0]  countNext;
  logic              ovSet, unSet, gateNext, liftNext;

  function automatic logic [HOLD_W-1:0] holdInc(input logic [HOLD_W-1:0] h);
    return (h >= HOLD_MAX) ? HOLD_MAX : h + HOLD_W'(1);
  endfunction

`ifdef SENSOR_SYNC_EN
  logic [1:0] syncIn, syncOut;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      syncIn  <= 2'b11;
      syncOut <= 2'b11;
    end else begin
      syncIn  <= {syncIn[0], CarIn};
      syncOut <= {syncOut[0], CarOut};
    end
  end

  assign carInS  = syncIn[1];
  assign carOutS = syncOut[1];
`else
  assign carInS  = CarIn;
  assign carOutS = CarOut;
`endif

  // Edge detect: prev flops reset high so a sensor held through reset is not a car
  assign inEdge  = carInS & ~prevIn;
  assign outEdge = carOutS & ~prevOut;

  always_comb begin
    countNext = Count;
    ovSet     = 1'b0;
    unSet     = 1'b0;
    unique case ({inEdge, outEdge})
      2'b10: if (Count == CAP) ovSet = 1'b1;
             else              countNext = Count + CNT_W'(1);
      2'b01: if (Count == '0)  unSet = 1'b1;
             else              countNext = Count - CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      prevIn    <= 1'b1;
      prevOut   <= 1'b1;
      Count     <= '0;
      ExistCar  <= 1'b0;
      Full      <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      Intrusion <= 1'b0;
    end else begin
      prevIn    <= carInS;
      prevOut   <= carOutS;
      Count     <= countNext;
      ExistCar  <= (countNext != '0);
      Full      <= (countNext == CAP);
      Overflow  <= ovSet | (Overflow & ~ClearErr);
      Underflow <= unSet | (Underflow & ~ClearErr);
      Intrusion <= (inEdge & ~GateOpen) | (Intrusion & ~ClearErr);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= OPEN;
      holdCnt  <= '0;
      GateOpen <= 1'b1;
      LiftOk   <= 1'b0;
    end else begin
      state    <= stateNext;
      holdCnt  <= holdNext;
      GateOpen <= gateNext;
      LiftOk   <= liftNext;
    end
  end

  // Hold counter only accumulates empty cycles while draining with the request held
  always_comb begin
    stateNext = state;
    holdNext  = '0;
    unique case (state)
      OPEN: if (LiftReq) stateNext = DRAINING;
      DRAINING: begin
        if (!LiftReq) begin
          stateNext = OPEN;
        end else begin
          holdNext = (Count == '0) ? holdInc(holdCnt) : '0;
          if (holdNext == HOLD_MAX) stateNext = CLEAR;
        end
      end
      CLEAR: begin
        if (!LiftReq)    stateNext = OPEN;
        else if (inEdge) stateNext = DRAINING;
      end
      default: stateNext = OPEN;
    endcase
  end

  always_comb begin
    gateNext = (stateNext == OPEN);
    liftNext = (stateNext == CLEAR);
  end

endmodule
